// File: rtl/radix4_step_sequencer_if.sv
// Handshake/pacing bundle between a requester and radix4_step_sequencer.
// The abort signal is present only when RADIX4_SEQ_ABORT_EN is defined.
interface radix4_step_sequencer_if #(
    parameter int unsigned DIV_W   = 5,
    parameter int unsigned STEPS_W = 4
);
    logic               start;
    logic [DIV_W-1:0]   div_val;
    logic [STEPS_W-1:0] num_steps;
    logic               busy;
    logic               load_strobe;
    logic               step_strobe;
    logic [STEPS_W-1:0] step_idx;
    logic               phase_clk;
    logic               done;
`ifdef RADIX4_SEQ_ABORT_EN
    logic               abort;

    modport master (
        output start, div_val, num_steps, abort,
        input  busy, load_strobe, step_strobe, step_idx, phase_clk, done
    );

    modport slave (
        input  start, div_val, num_steps, abort,
        output busy, load_strobe, step_strobe, step_idx, phase_clk, done
    );
`else
    modport master (
        output start, div_val, num_steps,
        input  busy, load_strobe, step_strobe, step_idx, phase_clk, done
    );

    modport slave (
        input  start, div_val, num_steps,
        output busy, load_strobe, step_strobe, step_idx, phase_clk, done
    );
`endif
endinterface

// File: rtl/radix4_step_sequencer.sv
// Pacing sequencer for the iterative radix-4 datapath: load strobe, divided step ticks, done pulse.
// Optional feature macro: RADIX4_SEQ_ABORT_EN (adds abort input that drops LOAD/RUN back to IDLE).
module radix4_step_sequencer #(
    parameter int unsigned DIV_W   = 5,
    parameter int unsigned STEPS_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    radix4_step_sequencer_if.slave bus
);
    localparam int unsigned PW = DIV_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   cnt, cnt_nxt;
    logic [DIV_W-1:0]   div_lat, div_nxt;
    logic [STEPS_W-1:0] steps_lat, steps_nxt;
    logic [STEPS_W-1:0] idx_q, idx_nxt;

    logic               abort_c;
    logic               tick_c;
    logic               phase_c;
    logic [PW-1:0]      cnt_x2_c;
    logic [PW-1:0]      period_c;
    logic               busy_c;
    logic               load_c;
    logic               step_c;
    logic               done_c;

`ifdef RADIX4_SEQ_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    // Tick decode: cnt runs 0..div_lat, so it never needs an explicit overflow wrap.
    assign tick_c   = (cnt == div_lat);
    assign cnt_x2_c = {cnt, 1'b0};
    assign period_c = PW'(div_lat) + PW'(1);
    assign phase_c  = (cnt_x2_c < period_c);

    // State and latched-operand registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            div_lat   <= '0;
            steps_lat <= '0;
            idx_q     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div_lat   <= div_nxt;
            steps_lat <= steps_nxt;
            idx_q     <= idx_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div_lat;
        steps_nxt = steps_lat;
        idx_nxt   = idx_q;
        busy_c    = 1'b0;
        load_c    = 1'b0;
        step_c    = 1'b0;
        done_c    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    div_nxt   = bus.div_val;
                    steps_nxt = bus.num_steps;
                    state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                busy_c  = 1'b1;
                cnt_nxt = '0;
                if (abort_c) begin
                    state_nxt = ST_IDLE;
                end else begin
                    load_c    = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                busy_c = 1'b1;
                if (abort_c) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (tick_c) begin
                    step_c  = 1'b1;
                    cnt_nxt = '0;
                    if (idx_q == steps_lat) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt = idx_q + STEPS_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                end
            end

            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_c;
    assign bus.load_strobe = load_c;
    assign bus.step_strobe = step_c;
    assign bus.done        = done_c;
    assign bus.step_idx    = idx_q;
    assign bus.phase_clk   = (state == ST_RUN) && phase_c;

    // The three pulses must never coincide.
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0({load_c, step_c, done_c}));

    // Step index never runs past the latched step count while running.
    assert property (@(posedge clk) disable iff (!rst_n) (state == ST_RUN) |-> (idx_q <= steps_lat));

endmodule

// File: tb/tb_radix4_step_sequencer.sv
// Scoreboard bench for radix4_step_sequencer: expected per-cycle outputs are queued at launch.
module tb_radix4_step_sequencer;
    localparam int unsigned DIV_W   = 5;
    localparam int unsigned STEPS_W = 4;

    typedef struct packed {
        logic               busy;
        logic               load;
        logic               step;
        logic               phase;
        logic               done;
        logic               idx_chk;
        logic [STEPS_W-1:0] idx;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    radix4_step_sequencer_if #(.DIV_W(DIV_W), .STEPS_W(STEPS_W)) bus();

    radix4_step_sequencer #(.DIV_W(DIV_W), .STEPS_W(STEPS_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t mk(input bit b, input bit l, input bit s, input bit p,
                                input bit d, input bit ic, input int idx);
        exp_t r;
        r.busy = b; r.load = l; r.step = s; r.phase = p; r.done = d;
        r.idx_chk = ic; r.idx = STEPS_W'(idx);
        return r;
    endfunction

    function automatic void push_idle(input int n, input bit ic = 1'b0);
        for (int k = 0; k < n; k++) sb.push_back(mk(0, 0, 0, 0, 0, ic, 0));
    endfunction

    // Reference trace built from the tick-period and step-count definitions.
    function automatic void push_seq(input int dv, input int ns);
        sb.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        for (int s = 0; s <= ns; s++)
            for (int c = 0; c <= dv; c++)
                sb.push_back(mk(1, 0, c == dv, (2 * c) < (dv + 1), 0, 1, s));
        sb.push_back(mk(0, 0, 0, 0, 1, 1, ns));
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.busy = bus.busy; o.load = bus.load_strobe; o.step = bus.step_strobe;
        o.phase = bus.phase_clk; o.done = bus.done;
        o.idx_chk = 1'b0; o.idx = bus.step_idx;
        return o;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input int dv, input int ns);
        bus.start     = st;
        bus.div_val   = DIV_W'(dv);
        bus.num_steps = STEPS_W'(ns);
    endtask

    task automatic scramble();
        bus.div_val   = DIV_W'($urandom);
        bus.num_steps = STEPS_W'($urandom);
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst_n = 1'b0;
        drive(1, 3, 2);
        push_idle(3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            e = sb.pop_front(); o = observe(); tests_run++;
            if ({o.busy, o.load, o.step, o.phase, o.done} !== {e.busy, e.load, e.step, e.phase, e.done}
                || (e.idx_chk && o.idx !== e.idx)) begin
                tests_failed++;
                $display("FAIL reset cyc %0d: got blspd=%b idx=%0d, expected blspd=%b idx=%0d", i,
                         {o.busy, o.load, o.step, o.phase, o.done}, o.idx,
                         {e.busy, e.load, e.step, e.phase, e.done}, e.idx);
            end
        end
        rst_n = 1'b1;
        drive(0, 0, 0);
    endtask

    task automatic test_sequence(input string name, input int dv, input int ns);
        exp_t e, o;
        int   n;
        push_idle(1);
        push_seq(dv, ns);
        push_idle(2);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            next_cycle();
            if (i == 0) drive(1, dv, ns);
            else begin
                bus.start = 1'b0;
                scramble();
            end
            #1;
            e = sb.pop_front(); o = observe(); tests_run++;
            if ({o.busy, o.load, o.step, o.phase, o.done} !== {e.busy, e.load, e.step, e.phase, e.done}
                || (e.idx_chk && o.idx !== e.idx)) begin
                tests_failed++;
                $display("FAIL %s cyc %0d: got blspd=%b idx=%0d, expected blspd=%b idx=%0d", name, i,
                         {o.busy, o.load, o.step, o.phase, o.done}, o.idx,
                         {e.busy, e.load, e.step, e.phase, e.done}, e.idx);
            end
        end
    endtask

    task automatic test_basic();
        test_sequence("basic_d3_s2", 3, 2);
    endtask

    task automatic test_fast();
        test_sequence("fast_d0_s15", 0, 15);
    endtask

    task automatic test_phase();
        test_sequence("phase_d4_s1", 4, 1);
        test_sequence("phase_d31_s0", 31, 0);
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        int   n;
        push_idle(1);
        for (int k = 0; k < 3; k++) begin
            push_seq(1, 0);
            push_idle(1);
        end
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            next_cycle();
            drive(i != n - 1, 1, 0);
            #1;
            e = sb.pop_front(); o = observe(); tests_run++;
            if ({o.busy, o.load, o.step, o.phase, o.done} !== {e.busy, e.load, e.step, e.phase, e.done}
                || (e.idx_chk && o.idx !== e.idx)) begin
                tests_failed++;
                $display("FAIL back_to_back cyc %0d: got blspd=%b idx=%0d, expected blspd=%b idx=%0d", i,
                         {o.busy, o.load, o.step, o.phase, o.done}, o.idx,
                         {e.busy, e.load, e.step, e.phase, e.done}, e.idx);
            end
        end
        drive(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        push_idle(1);
        push_seq(2, 5);
        // Record 8 is the first cycle of step 2; reset is applied at the following edge.
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            if (i == 0) drive(1, 2, 5);
            else bus.start = 1'b0;
            #1;
            e = sb.pop_front(); o = observe(); tests_run++;
            if ({o.busy, o.load, o.step, o.phase, o.done} !== {e.busy, e.load, e.step, e.phase, e.done}
                || (e.idx_chk && o.idx !== e.idx)) begin
                tests_failed++;
                $display("FAIL reset_mid_pre cyc %0d: got blspd=%b idx=%0d, expected blspd=%b idx=%0d", i,
                         {o.busy, o.load, o.step, o.phase, o.done}, o.idx,
                         {e.busy, e.load, e.step, e.phase, e.done}, e.idx);
            end
            if (i == 8) rst_n = 1'b0;
        end
        sb.delete();
        push_idle(4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            e = sb.pop_front(); o = observe(); tests_run++;
            if ({o.busy, o.load, o.step, o.phase, o.done} !== {e.busy, e.load, e.step, e.phase, e.done}
                || (e.idx_chk && o.idx !== e.idx)) begin
                tests_failed++;
                $display("FAIL reset_mid_post cyc %0d: got blspd=%b idx=%0d, expected blspd=%b idx=%0d", i,
                         {o.busy, o.load, o.step, o.phase, o.done}, o.idx,
                         {e.busy, e.load, e.step, e.phase, e.done}, e.idx);
            end
            rst_n = 1'b1;
        end
        test_sequence("restart_d1_s1", 1, 1);
    endtask

`ifdef RADIX4_SEQ_ABORT_EN
    task automatic test_abort();
        exp_t e, o, t;
        int   n;
        // Abort on the final step strobe: strobe suppressed, no done, IDLE next.
        push_idle(1);
        push_seq(2, 1);
        t = sb[7]; t.step = 1'b0; sb[7] = t;
        sb[8] = mk(0, 0, 0, 0, 0, 0, 0);
        push_idle(1);
        // Abort in IDLE alongside start, and in DONE: both have no effect.
        push_idle(1);
        push_seq(1, 0);
        push_idle(1);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            next_cycle();
            if (i == 0) drive(1, 2, 1);
            else if (i == 10) drive(1, 1, 0);
            else bus.start = 1'b0;
            bus.abort = (i == 7) || (i == 10) || (i == 14);
            #1;
            e = sb.pop_front(); o = observe(); tests_run++;
            if ({o.busy, o.load, o.step, o.phase, o.done} !== {e.busy, e.load, e.step, e.phase, e.done}
                || (e.idx_chk && o.idx !== e.idx)) begin
                tests_failed++;
                $display("FAIL abort cyc %0d: got blspd=%b idx=%0d, expected blspd=%b idx=%0d", i,
                         {o.busy, o.load, o.step, o.phase, o.done}, o.idx,
                         {e.busy, e.load, e.step, e.phase, e.done}, e.idx);
            end
        end
        bus.abort = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 0, 0);
`ifdef RADIX4_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_fast();
        test_phase();
        test_back_to_back();
        test_reset_mid();
`ifdef RADIX4_SEQ_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
